// File: rtl/watchdog_reset_ctrl.sv
// Turns a watchdog bite into a timed system reset request followed by a holdoff
// window, with saturating event counters and a control/status register pair.
module watchdog_reset_ctrl #(
  parameter int unsigned               DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0]     REG_ADDR       = 8'hE0,
  parameter int unsigned               RESET_CYCLES   = 1024,
  parameter int unsigned               HOLDOFF_CYCLES = 256,
  parameter logic                      ARM_AT_RESET   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] adr_wr_i,
  input  logic [DATA_WIDTH-1:0] adr_rd_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  input  logic                  dog_bite,
  input  logic                  non_zero_pulse,
  output logic                  sys_reset_req,
  output logic                  busy
);

  localparam int unsigned           CNT_W        = 16;
  localparam logic [DATA_WIDTH-1:0] CNT_ADDR     = REG_ADDR + DATA_WIDTH'(1);
  localparam logic [CNT_W-1:0]      ASSERT_LOAD  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]      HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic             armed_q, armed_d;
  logic [3:0]       bite_count_q, bite_count_d;
  logic [7:0]       nz_count_q, nz_count_d;
  logic             dog_bite_q;
  logic             sys_reset_req_q, sys_reset_req_d;
  logic             busy_q, busy_d;

  logic wr_c, clear_c, force_c, bite_edge_c, bite_trig_c;
  logic unused_dat_bits;

  assign wr_c        = stb_i & we_i & (adr_wr_i == REG_ADDR);
  assign clear_c     = wr_c & dat_i[1];
  assign force_c     = wr_c & dat_i[7];
  assign bite_edge_c = dog_bite & ~dog_bite_q;
  assign bite_trig_c = bite_edge_c & armed_q;
  assign unused_dat_bits = ^dat_i;

  assign ack_o         = stb_i;
  assign sys_reset_req = sys_reset_req_q;
  assign busy          = busy_q;

  // Register read mux
  always_comb begin
    dat_o = '0;
    if (adr_rd_i == REG_ADDR) begin
      dat_o = DATA_WIDTH'({armed_q, busy_q, 2'b00, bite_count_q});
    end else if (adr_rd_i == CNT_ADDR) begin
      dat_o = DATA_WIDTH'(nz_count_q);
    end
  end

  // State register and all bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cyc_cnt_q       <= '0;
      armed_q         <= ARM_AT_RESET;
      bite_count_q    <= '0;
      nz_count_q      <= '0;
      dog_bite_q      <= 1'b1;
      sys_reset_req_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cyc_cnt_q       <= cyc_cnt_d;
      armed_q         <= armed_d;
      bite_count_q    <= bite_count_d;
      nz_count_q      <= nz_count_d;
      dog_bite_q      <= dog_bite;
      sys_reset_req_q <= sys_reset_req_d;
      busy_q          <= busy_d;
    end
  end

  // Next-state: triggers are only honoured from IDLE; clear beats any increment
  always_comb begin
    state_d      = state_q;
    cyc_cnt_d    = cyc_cnt_q;
    armed_d      = armed_q;
    bite_count_d = bite_count_q;
    nz_count_d   = nz_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bite_trig_c || force_c) begin
          state_d   = ST_ASSERT;
          cyc_cnt_d = ASSERT_LOAD;
          if (bite_trig_c && (bite_count_q != 4'hF)) begin
            bite_count_d = bite_count_q + 4'd1;
          end
        end
      end
      ST_ASSERT: begin
        if (cyc_cnt_q == '0) begin
          state_d   = ST_HOLDOFF;
          cyc_cnt_d = HOLDOFF_LOAD;
        end else begin
          cyc_cnt_d = cyc_cnt_q - CNT_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (cyc_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cyc_cnt_d = cyc_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cyc_cnt_d = '0;
      end
    endcase

    if (non_zero_pulse && (nz_count_q != 8'hFF)) begin
      nz_count_d = nz_count_q + 8'd1;
    end
    if (clear_c) begin
      bite_count_d = '0;
      nz_count_d   = '0;
    end
    if (wr_c) begin
      armed_d = dat_i[0];
    end

    sys_reset_req_d = (state_d == ST_ASSERT);
    busy_d          = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_watchdog_reset_ctrl.sv
// Bench for watchdog_reset_ctrl: timestamp-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_watchdog_reset_ctrl;

  localparam int R = 1024;
  localparam int H = 256;
  localparam logic [7:0] A_CTRL = 8'hE0;
  localparam logic [7:0] A_CNT  = 8'hE1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stb_i = 1'b0, we_i = 1'b0;
  logic [7:0] adr_wr_i = '0, adr_rd_i = '0, dat_i = '0;
  logic [7:0] dat_o;
  logic       ack_o;
  logic       dog_bite = 1'b1, non_zero_pulse = 1'b0;
  logic       sys_reset_req, busy;

  int total = 0;
  int bad   = 0;

  watchdog_reset_ctrl dut (
    .clk(clk), .reset(reset), .stb_i(stb_i), .we_i(we_i),
    .adr_wr_i(adr_wr_i), .adr_rd_i(adr_rd_i), .dat_i(dat_i), .dat_o(dat_o),
    .ack_o(ack_o), .dog_bite(dog_bite), .non_zero_pulse(non_zero_pulse),
    .sys_reset_req(sys_reset_req), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a trigger at edge n means request high through edge
  // n+R-1 and busy through n+R+H-1; the block is idle when the previous edge
  // lies outside the busy window.
  int   n = 0;
  int   req_last = -1, busy_last = -1;
  logic m_armed = 1'b0, m_prev = 1'b1;
  int   m_bites = 0, m_nz = 0;

  always @(posedge clk) begin
    logic wr, idle, bite_edge;
    n++;
    if (reset) begin
      m_armed = 1'b0; m_bites = 0; m_nz = 0; m_prev = 1'b1;
      req_last = -1; busy_last = -1;
    end else begin
      wr        = stb_i && we_i && (adr_wr_i == A_CTRL);
      idle      = (n - 1) > busy_last;
      bite_edge = dog_bite && !m_prev;
      if (idle && ((bite_edge && m_armed) || (wr && dat_i[7]))) begin
        req_last  = n + R - 1;
        busy_last = n + R + H - 1;
        if (bite_edge && m_armed && m_bites < 15) m_bites++;
      end
      if (non_zero_pulse && m_nz < 255) m_nz++;
      if (wr && dat_i[1]) begin m_bites = 0; m_nz = 0; end
      if (wr) m_armed = dat_i[0];
      m_prev = dog_bite;
    end
  end

  // Per-cycle comparison against the model, plus pulse-length monitors
  int req_cnt = 0, busy_cnt = 0;
  always @(negedge clk) begin
    logic e_req, e_busy;
    logic [7:0] e_dat;
    if (n > 0) begin
      e_req  = (n <= req_last);
      e_busy = (n <= busy_last);
      if (adr_rd_i == A_CTRL)     e_dat = {m_armed, e_busy, 2'b00, 4'(m_bites)};
      else if (adr_rd_i == A_CNT) e_dat = 8'(m_nz);
      else                        e_dat = 8'h00;
      chk("model_req",  32'(sys_reset_req), 32'(e_req));
      chk("model_busy", 32'(busy), 32'(e_busy));
      chk("model_dat",  32'(dat_o), 32'(e_dat));
      chk("model_ack",  32'(ack_o), 32'(stb_i));
      if (sys_reset_req) req_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic step(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    stb_i = 1'b1; we_i = 1'b1; adr_wr_i = a; dat_i = d;
    step();
    stb_i = 1'b0; we_i = 1'b0; adr_wr_i = '0; dat_i = '0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    adr_rd_i = a;
    #1;
    chk(name, 32'(dat_o), 32'(exp));
  endtask

  initial begin
    // Reset with a bite already high, then arm: no edge, so no request
    step(3);
    reset = 1'b0;
    step();
    chk("reset_req",  32'(sys_reset_req), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rd_chk("reset_ctrl", A_CTRL, 8'h00);
    wr_reg(A_CTRL, 8'h01);
    req_cnt = 0;
    step(2000);
    chk("held_bite_no_req", 32'(req_cnt), 32'd0);
    rd_chk("held_bite_ctrl", A_CTRL, 8'h80);

    // Armed bite edge: request exactly R cycles, busy R+H
    dog_bite = 1'b0;
    step();
    req_cnt = 0; busy_cnt = 0;
    dog_bite = 1'b1;
    step();
    chk("first_req_latency", 32'(sys_reset_req), 32'd1);
    step(1300);
    chk("bite_req_len",  32'(req_cnt), 32'd1024);
    chk("bite_busy_len", 32'(busy_cnt), 32'd1280);
    rd_chk("bite_done_ctrl", A_CTRL, 8'h81);

    // Disarmed bite ignored; force works while disarmed and is not counted
    wr_reg(A_CTRL, 8'h02);
    dog_bite = 1'b0;
    step();
    req_cnt = 0;
    dog_bite = 1'b1;
    step(10);
    chk("disarmed_no_req", 32'(req_cnt), 32'd0);
    wr_reg(A_CTRL, 8'h80);
    step(1300);
    chk("force_req_len", 32'(req_cnt), 32'd1024);
    rd_chk("force_ctrl", A_CTRL, 8'h00);

    // Bite during HOLDOFF dropped; fresh edge after IDLE retriggers
    wr_reg(A_CTRL, 8'h01);
    dog_bite = 1'b0;
    step();
    req_cnt = 0;
    dog_bite = 1'b1;
    step(1100);
    dog_bite = 1'b0;
    step();
    dog_bite = 1'b1;
    step(5);
    rd_chk("holdoff_ctrl", A_CTRL, 8'hC1);
    step(300);
    chk("holdoff_drop_req", 32'(req_cnt), 32'd1024);
    dog_bite = 1'b0;
    step();
    dog_bite = 1'b1;
    step(1300);
    chk("retrigger_req", 32'(req_cnt), 32'd2048);
    rd_chk("retrigger_ctrl", A_CTRL, 8'h82);

    // nz_count saturation, ignored count-register write, clear collision
    for (int i = 0; i < 300; i++) begin
      non_zero_pulse = 1'b1;
      step();
      non_zero_pulse = 1'b0;
      step();
    end
    rd_chk("nz_sat", A_CNT, 8'hFF);
    req_cnt = 0;
    wr_reg(A_CNT, 8'h83);
    step(3);
    chk("cnt_write_no_force", 32'(req_cnt), 32'd0);
    rd_chk("cnt_write_ctrl", A_CTRL, 8'h82);
    rd_chk("other_addr", 8'h10, 8'h00);
    non_zero_pulse = 1'b1;
    wr_reg(A_CTRL, 8'h02);
    non_zero_pulse = 1'b0;
    rd_chk("clear_vs_pulse", A_CNT, 8'h00);

    // Reset in the middle of ASSERT
    wr_reg(A_CTRL, 8'h01);
    dog_bite = 1'b0;
    step();
    dog_bite = 1'b1;
    step(500);
    chk("mid_assert_req", 32'(sys_reset_req), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_req",  32'(sys_reset_req), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    rd_chk("rst_mid_ctrl", A_CTRL, 8'h00);
    step(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/watchdog_reset_ctrl.md
Name: watchdog_reset_ctrl

Overview:
- Downstream consumer of the debug counter/watchdog stage.
- Takes its dog_bite and non_zero_pulse outputs and turns a watchdog timeout into a timed system reset request with a post-reset holdoff window.
- Keeps saturating event counters and control/status registers on the same strobe/ack register bus used by the neighbouring peripherals.
- Firmware can arm or disarm the watchdog reset, force a reset, and read back bite and non-zero-write history.

Parameters:
- REG_ADDR, 8'hE0, control/status register address; the count register sits at REG_ADDR+1.
- DATA_WIDTH, 8, bus data/address width.
- RESET_CYCLES, 1024, sys_reset_req high time in clk cycles (≥1, ≤65536).
- HOLDOFF_CYCLES, 256, post-reset window in which bites are ignored (≥1, ≤65536).
- ARM_AT_RESET, 1'b0, reset value of the armed bit.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- stb_i  in  1  bus strobe
- we_i  in  1  bus write enable
- adr_wr_i  in  DATA_WIDTH  write address
- adr_rd_i  in  DATA_WIDTH  read address
- dat_i  in  DATA_WIDTH  write data
- dat_o  out  DATA_WIDTH  read data, combinational from adr_rd_i
- ack_o  out  1  equals stb_i
- dog_bite  in  1  watchdog timeout level from the upstream stage
- non_zero_pulse  in  1  one-cycle pulse from the upstream stage
- sys_reset_req  out  1  registered system reset request
- busy  out  1  high in ASSERT or HOLDOFF

Behaviour:
- Single clock domain is clk. reset is synchronous and active-high: all state updates on posedge clk, with reset taking priority.
- Reset values:
  - state=IDLE, sys_reset_req=0, busy=0
  - armed=ARM_AT_RESET
  - bite_count=0, nz_count=0, cyc_cnt=0
  - dog_bite_d=1, so a bite already high at reset release is not an edge
- Write decode: wr = stb_i & we_i & (adr_wr_i==REG_ADDR). On wr:
  - armed <= dat_i[0]
  - dat_i[1] = clear counts (one-shot, not stored)
  - dat_i[7] = force reset (one-shot)
  - Writes to REG_ADDR+1 are ignored.
- Read map:
  - adr_rd_i==REG_ADDR: dat_o = {armed, busy, 2'b00, bite_count[3:0]}
  - adr_rd_i==REG_ADDR+1: dat_o = nz_count[7:0]
  - any other address: dat_o = 0
- Edge detect: bite_edge = dog_bite & ~dog_bite_d; dog_bite_d <= dog_bite every cycle.
- FSM transitions:
  - IDLE -> ASSERT when (bite_edge & armed) or (wr & dat_i[7]). Load cyc_cnt=RESET_CYCLES-1. bite_count increments (saturating at 15) only when bite_edge caused the entry.
  - ASSERT: sys_reset_req=1. Decrement cyc_cnt; at cyc_cnt==0 go to HOLDOFF and load HOLDOFF_CYCLES-1.
  - HOLDOFF: sys_reset_req=0. Decrement cyc_cnt; at 0 go to IDLE.
- sys_reset_req timing: registered. First high the cycle after the triggering edge; stays high exactly RESET_CYCLES cycles.
- Ignored events:
  - Bite edges and force writes in ASSERT/HOLDOFF are dropped, not queued, and not counted.
  - A dog_bite level that stays high across the return to IDLE does not retrigger; a new rising edge is required.
- Disarm (armed <= 0) during ASSERT/HOLDOFF does not abort the sequence. Force works while disarmed.
- nz_count: increments on non_zero_pulse, saturating at 255.
- Clear collisions: clear_counts in the same cycle as a bite entry or a non_zero_pulse wins; the counter ends at 0.
- Reset asserted mid-ASSERT: sys_reset_req drops the following cycle and the FSM returns to IDLE.
- Counter widths: cyc_cnt is 16 bits; no wrap is possible because the FSM leaves each state at 0.

Test Plan:
- Reset with dog_bite=1 held, armed=1 -> sys_reset_req stays 0 for 2000 cycles; bite_count=0.
- Write 8'h01 to REG_ADDR, then raise dog_bite -> sys_reset_req high exactly 1024 cycles starting 1 cycle after the edge; busy high 1280 cycles; read REG_ADDR = 8'h81 after completion.
- armed=0, dog_bite edge -> no request; then write 8'h80 -> 1024-cycle request; bite_count unchanged at 0.
- Second dog_bite edge during HOLDOFF (cycle 1100 of the sequence) -> ignored, bite_count stays 1; an edge after return to IDLE -> new request, bite_count=2.
- 300 non_zero_pulse pulses -> read REG_ADDR+1 = 8'hFF; write 8'h02 coincident with a pulse -> reads 8'h00 next cycle.
- Assert reset at cycle 500 of ASSERT -> sys_reset_req=0 and busy=0 the next cycle; armed returns to ARM_AT_RESET.
